smvm_stream_adapter: RTL and testbench

Parametrised AXI-Stream front/back end for the SMVM core. It pairs 32-bit header and value words from the receive FIFO into core input transactions (row, column, data, mode, end-of-packet), and serialises wide core results into byte-swapped 32-bit beats for the send FIFO. It replaces the fixed-width converter with real backpressure, tlast-based packet framing, a result buffer, overflow detection and configurable index/result widths.

---
 rtl/smvm_pkg.sv | 15 +
 rtl/smvm_result_fifo.sv | 51 +++++
 rtl/smvm_stream_adapter.sv | 174 +++++++++++++++++
 tb/tb_smvm_stream_adapter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/smvm_pkg.sv
// Shared SMVM definitions: mode encodings, vector marker words, input FSM states and byte swap.
package smvm_pkg;

   localparam logic        SMVM_MODE_VEC      = 1'b1;
   localparam logic        SMVM_MODE_MAT      = 1'b0;
   localparam logic [31:0] SMVM_VEC_MARK_ONES = 32'hFFFF_FFFF;
   localparam logic [31:0] SMVM_VEC_MARK_ZERO = 32'h0000_0000;

   typedef enum logic {StHdr, StVal} in_state_e;

   function automatic logic [31:0] byteswap32(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

endpackage

// File: rtl/smvm_result_fifo.sv
// Synchronous result FIFO with occupancy count; a push while full is accepted only alongside a pop.
module smvm_result_fifo #(
   parameter int unsigned WIDTH = 65,
   parameter int unsigned DEPTH = 8,
   localparam int unsigned AW = $clog2(DEPTH),
   localparam int unsigned CW = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             do_push, do_pop;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr_q];
   assign count   = count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/smvm_stream_adapter.sv
// AXI-Stream adapter for the SMVM core: header/value pairing in, result serialisation out.
// Optional statistics counters are enabled with SMVM_ADAPT_STATS_EN.
module smvm_stream_adapter
   import smvm_pkg::*;
#(
   parameter int unsigned IDX_W      = 12,
   parameter int unsigned RES_W      = 76,
   parameter int unsigned OUT_BEATS  = 2,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned FIFO_RSV   = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      s_axis_tdata,
   input  logic [3:0]       s_axis_tkeep,
   input  logic             s_axis_tlast,
   input  logic             s_axis_tvalid,
   output logic             s_axis_tready,
   output logic             core_valid,
   output logic             core_eop,
   output logic             core_transmod,
   output logic [31:0]      core_data,
   output logic [IDX_W-1:0] core_row,
   output logic [IDX_W-1:0] core_col,
   input  logic             res_valid,
   input  logic             res_eop,
   input  logic [RES_W-1:0] res_data,
   output logic [31:0]      m_axis_tdata,
   output logic [3:0]       m_axis_tkeep,
   output logic             m_axis_tlast,
   output logic             m_axis_tvalid,
   input  logic             m_axis_tready,
   output logic             err_frame,
   output logic             err_ovf,
   output logic [31:0]      stat_pairs,
   output logic [31:0]      stat_results
);

   localparam int unsigned DATA_W  = 32 * OUT_BEATS;
   localparam int unsigned ENTRY_W = DATA_W + 1;
   localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned BEAT_W  = (OUT_BEATS > 1) ? $clog2(OUT_BEATS) : 1;

   in_state_e          state_q, state_d;
   logic [31:0]        hdr_q;
   logic               rst_done_q;
   logic               in_hs, hdr_load, frame_err, pair_fire, pair_zero;
   logic [15:0]        row_sw, col_sw;
   logic [31:0]        free_entries;
   logic [CNT_W-1:0]   fifo_count;
   logic               fifo_full, fifo_empty, fifo_pop, push_ok;
   logic [ENTRY_W-1:0] fifo_head;
   logic [DATA_W-1:0]  head_shift;
   logic [BEAT_W-1:0]  beat_q;
   logic               last_beat;
   logic               unused_tkeep;

   assign unused_tkeep  = ^s_axis_tkeep;
   assign free_entries  = FIFO_DEPTH - 32'(fifo_count);
   assign s_axis_tready = rst_done_q && (free_entries >= FIFO_RSV);
   assign in_hs         = s_axis_tvalid && s_axis_tready;

   always_comb begin
      state_d   = state_q;
      hdr_load  = 1'b0;
      frame_err = 1'b0;
      pair_fire = 1'b0;
      if (in_hs) begin
         case (state_q)
            StHdr: begin
               if (s_axis_tlast) frame_err = 1'b1;
               else begin
                  hdr_load = 1'b1;
                  state_d  = StVal;
               end
            end
            StVal: begin
               pair_fire = 1'b1;
               state_d   = StHdr;
            end
            default: state_d = StHdr;
         endcase
      end
   end

   assign row_sw    = {hdr_q[7:0], hdr_q[15:8]};
   assign col_sw    = {hdr_q[23:16], hdr_q[31:24]};
   assign pair_zero = (hdr_q == SMVM_VEC_MARK_ZERO) && (s_axis_tdata == 32'h0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StHdr;
         hdr_q         <= '0;
         rst_done_q    <= 1'b0;
         err_frame     <= 1'b0;
         core_valid    <= 1'b0;
         core_eop      <= 1'b0;
         core_transmod <= 1'b0;
         core_data     <= '0;
         core_row      <= '0;
         core_col      <= '0;
      end else begin
         state_q    <= state_d;
         rst_done_q <= 1'b1;
         if (hdr_load)  hdr_q     <= s_axis_tdata;
         if (frame_err) err_frame <= 1'b1;
         core_valid <= pair_fire && !pair_zero;
         core_eop   <= pair_fire && s_axis_tlast;
         if (pair_fire) begin
            core_row      <= IDX_W'(row_sw);
            core_col      <= IDX_W'(col_sw);
            core_data     <= byteswap32(s_axis_tdata);
            core_transmod <= (hdr_q == SMVM_VEC_MARK_ONES || hdr_q == SMVM_VEC_MARK_ZERO) ?
                             SMVM_MODE_VEC : SMVM_MODE_MAT;
         end
      end
   end

   smvm_result_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (res_valid),
      .push_data ({DATA_W'(res_data), res_eop}),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Beats leave most-significant first; beat_q selects the slice of the head entry.
   assign head_shift    = fifo_head[ENTRY_W-1:1] >> (32 * (OUT_BEATS - 1 - 32'(beat_q)));
   assign last_beat     = (32'(beat_q) == OUT_BEATS - 1);
   assign m_axis_tvalid = !fifo_empty;
   assign m_axis_tdata  = m_axis_tvalid ? byteswap32(32'(head_shift)) : 32'h0;
   assign m_axis_tkeep  = {4{m_axis_tvalid}};
   assign m_axis_tlast  = m_axis_tvalid && last_beat && fifo_head[0];
   assign fifo_pop      = m_axis_tvalid && m_axis_tready && last_beat;
   assign push_ok       = res_valid && (!fifo_full || fifo_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_q  <= '0;
         err_ovf <= 1'b0;
      end else begin
         if (m_axis_tvalid && m_axis_tready) beat_q <= last_beat ? '0 : beat_q + 1'b1;
         if (res_valid && !push_ok) err_ovf <= 1'b1;
      end
   end

`ifdef SMVM_ADAPT_STATS_EN
   logic [31:0] pairs_q, results_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pairs_q   <= '0;
         results_q <= '0;
      end else begin
         if (pair_fire && !pair_zero) pairs_q <= pairs_q + 32'd1;
         if (push_ok) results_q <= results_q + 32'd1;
      end
   end

   assign stat_pairs   = pairs_q;
   assign stat_results = results_q;
`else
   assign stat_pairs   = 32'h0;
   assign stat_results = 32'h0;
`endif

endmodule

// File: tb/tb_smvm_stream_adapter.sv
// Bench for smvm_stream_adapter: directed literal checks plus random traffic against a queue model.
module tb_smvm_stream_adapter;

   localparam int IDX_W = 12;
   localparam int RES_W = 76;
   localparam int OUT_BEATS = 2;
   localparam int DEPTH = 8;
   localparam int RSV = 3;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [31:0]      s_axis_tdata = '0;
   logic [3:0]       s_axis_tkeep = 4'hF;
   logic             s_axis_tlast = 1'b0;
   logic             s_axis_tvalid = 1'b0;
   logic             s_axis_tready;
   logic             core_valid, core_eop, core_transmod;
   logic [31:0]      core_data;
   logic [IDX_W-1:0] core_row, core_col;
   logic             res_valid = 1'b0;
   logic             res_eop = 1'b0;
   logic [RES_W-1:0] res_data = '0;
   logic [31:0]      m_axis_tdata;
   logic [3:0]       m_axis_tkeep;
   logic             m_axis_tlast, m_axis_tvalid;
   logic             m_axis_tready = 1'b1;
   logic             err_frame, err_ovf;
   logic [31:0]      stat_pairs, stat_results;

   always #5 clk = ~clk;

   smvm_stream_adapter #(
      .IDX_W      (IDX_W),
      .RES_W      (RES_W),
      .OUT_BEATS  (OUT_BEATS),
      .FIFO_DEPTH (DEPTH),
      .FIFO_RSV   (RSV)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tkeep  (s_axis_tkeep),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .core_valid    (core_valid),
      .core_eop      (core_eop),
      .core_transmod (core_transmod),
      .core_data     (core_data),
      .core_row      (core_row),
      .core_col      (core_col),
      .res_valid     (res_valid),
      .res_eop       (res_eop),
      .res_data      (res_data),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tkeep  (m_axis_tkeep),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .err_frame     (err_frame),
      .err_ovf       (err_ovf),
      .stat_pairs    (stat_pairs),
      .stat_results  (stat_results)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         if (errors <= 40) $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic [31:0] swap(input logic [31:0] x);
      return ((x & 32'hFF) << 24) | (((x >> 8) & 32'hFF) << 16) |
             (((x >> 16) & 32'hFF) << 8) | ((x >> 24) & 32'hFF);
   endfunction

   // Reference model: expected beats flattened into a queue, entry occupancy as a plain count.
   typedef struct {logic [31:0] w; bit last; bit fin;} beat_t;
   beat_t       bq[$];
   int          occ = 0;
   bit          seen = 0, have_hdr = 0;
   logic [31:0] hdr = '0;
   bit          e_cv = 0, e_ceop = 0, e_tm = 0, e_ef = 0, e_eo = 0;
   logic [31:0] e_row = '0, e_col = '0, e_data = '0;
   logic [31:0] e_pairs = '0, e_results = '0;

   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_s_tready", s_axis_tready, 0);
         chk("rst_core_valid", core_valid, 0);
         chk("rst_core_eop", core_eop, 0);
         chk("rst_m_tvalid", m_axis_tvalid, 0);
         chk("rst_m_tkeep", m_axis_tkeep, 0);
         chk("rst_err_frame", err_frame, 0);
         chk("rst_err_ovf", err_ovf, 0);
         chk("rst_stat_pairs", stat_pairs, 0);
         bq.delete();
         occ = 0; seen = 0; have_hdr = 0; hdr = '0;
         e_cv = 0; e_ceop = 0; e_ef = 0; e_eo = 0; e_pairs = '0; e_results = '0;
      end else begin
         bit rdy;
         rdy = seen && ((DEPTH - occ) >= RSV);
         chk("s_tready", s_axis_tready, rdy);
         chk("core_valid", core_valid, e_cv);
         chk("core_eop", core_eop, e_ceop);
         if (e_cv) begin
            chk("core_row", core_row, e_row);
            chk("core_col", core_col, e_col);
            chk("core_data", core_data, e_data);
            chk("core_transmod", core_transmod, e_tm);
         end
         chk("m_tvalid", m_axis_tvalid, bq.size() > 0);
         chk("m_tkeep", m_axis_tkeep, (bq.size() > 0) ? 4'hF : 4'h0);
         if (bq.size() > 0) begin
            chk("m_tdata", m_axis_tdata, bq[0].w);
            chk("m_tlast", m_axis_tlast, bq[0].last);
         end
         chk("err_frame", err_frame, e_ef);
         chk("err_ovf", err_ovf, e_eo);
`ifdef SMVM_ADAPT_STATS_EN
         chk("stat_pairs", stat_pairs, e_pairs);
         chk("stat_results", stat_results, e_results);
`else
         chk("stat_pairs", stat_pairs, 0);
         chk("stat_results", stat_results, 0);
`endif
         // Events of the coming clock edge.
         e_cv = 0; e_ceop = 0;
         if (s_axis_tvalid && rdy) begin
            if (!have_hdr) begin
               if (s_axis_tlast) e_ef = 1;
               else begin hdr = s_axis_tdata; have_hdr = 1; end
            end else begin
               have_hdr = 0;
               e_ceop = s_axis_tlast;
               if (!(hdr == 0 && s_axis_tdata == 0)) begin
                  e_cv = 1;
                  e_pairs = e_pairs + 1;
               end
               e_row  = (((hdr & 32'hFF) << 8) | ((hdr >> 8) & 32'hFF)) % (1 << IDX_W);
               e_col  = ((((hdr >> 16) & 32'hFF) << 8) | (hdr >> 24)) % (1 << IDX_W);
               e_data = swap(s_axis_tdata);
               e_tm   = (hdr == 32'hFFFF_FFFF) || (hdr == 0);
            end
         end
         if (bq.size() > 0 && m_axis_tready) begin
            beat_t b;
            b = bq.pop_front();
            if (b.fin) occ--;
         end
         if (res_valid) begin
            if (occ < DEPTH) begin
               logic [63:0] d;
               d = res_data[63:0];
               for (int k = OUT_BEATS - 1; k >= 0; k--) begin
                  beat_t nb;
                  nb.w    = swap(32'(d >> (32 * k)));
                  nb.fin  = (k == 0);
                  nb.last = (k == 0) && res_eop;
                  bq.push_back(nb);
               end
               occ++;
               e_results = e_results + 1;
            end else e_eo = 1;
         end
         seen = 1;
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic send_word(input logic [31:0] d, input logic last);
      int n = 0;
      s_axis_tdata = d; s_axis_tlast = last; s_axis_tvalid = 1'b1;
      @(negedge clk);
      while (!s_axis_tready && n < 200) begin @(negedge clk); n++; end
      if (!s_axis_tready) chk("send_timeout", 0, 1);
      @(posedge clk); #1;
      s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      m_axis_tready = 1'b1;
      @(negedge clk);
      while (m_axis_tvalid && n < 200) begin @(negedge clk); n++; end
      chk("drain_timeout", m_axis_tvalid, 0);
      step();
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("lit_tready_after_rst_first", s_axis_tready, 0);
      step();
      @(negedge clk);
      chk("lit_tready_up", s_axis_tready, 1);
      step();

      send_word(32'h2301_0100, 0);
      send_word(32'h0000_803F, 0);
      @(negedge clk);
      chk("lit1_valid", core_valid, 1);
      chk("lit1_row", core_row, 12'h001);
      chk("lit1_col", core_col, 12'h123);
      chk("lit1_data", core_data, 32'h3F80_0000);
      chk("lit1_transmod", core_transmod, 0);
      chk("lit1_eop", core_eop, 0);
      step();

      send_word(32'hFFFF_FFFF, 0);
      send_word(32'h0000_0040, 1);
      @(negedge clk);
      chk("lit2_valid", core_valid, 1);
      chk("lit2_transmod", core_transmod, 1);
      chk("lit2_data", core_data, 32'h4000_0000);
      chk("lit2_eop", core_eop, 1);
      step();

      send_word(32'h0, 0);
      send_word(32'h0, 0);
      @(negedge clk);
      chk("lit3_zero_valid", core_valid, 0);
      step();
      send_word(32'h0200_0300, 0);
      send_word(32'h0100_0000, 0);
      @(negedge clk);
      chk("lit3_valid", core_valid, 1);
      chk("lit3_row", core_row, 12'h003);
      chk("lit3_col", core_col, 12'h002);
      chk("lit3_data", core_data, 32'h0000_0001);
      step();

      send_word(32'h1234_5678, 1);
      @(negedge clk);
      chk("lit4_err_frame", err_frame, 1);
      chk("lit4_valid", core_valid, 0);
      step();
      send_word(32'h0000_0100, 0);
      send_word(32'h1111_1111, 0);
      @(negedge clk);
      chk("lit4_valid_after", core_valid, 1);
      chk("lit4_row", core_row, 12'h001);
      chk("lit4_col", core_col, 12'h000);
      step();

      m_axis_tready = 1'b0;
      res_data = {12'hABC, 64'h1122_3344_5566_7788}; res_eop = 1'b1; res_valid = 1'b1;
      step();
      res_valid = 1'b0;
      @(negedge clk);
      chk("lit5_tvalid", m_axis_tvalid, 1);
      chk("lit5_beat0", m_axis_tdata, 32'h4433_2211);
      chk("lit5_tlast0", m_axis_tlast, 0);
      repeat (4) begin
         step();
         @(negedge clk);
         chk("lit5_stable", m_axis_tdata, 32'h4433_2211);
      end
      step();
      m_axis_tready = 1'b1;
      @(negedge clk);
      chk("lit5_beat0_hs", m_axis_tdata, 32'h4433_2211);
      step();
      @(negedge clk);
      chk("lit5_beat1", m_axis_tdata, 32'h8877_6655);
      chk("lit5_tlast1", m_axis_tlast, 1);
      step();
      @(negedge clk);
      chk("lit5_empty", m_axis_tvalid, 0);
      step();

      m_axis_tready = 1'b0;
      for (int i = 0; i < 9; i++) begin
         res_data = {12'h0, 32'hA000_0000 + 32'(i), 32'hB000_0000 + 32'(i)};
         res_eop = i[0]; res_valid = 1'b1;
         @(negedge clk);
         chk("lit6_tready", s_axis_tready, i <= 5);
         chk("lit6_ovf_clear", err_ovf, 0);
         step();
      end
      res_valid = 1'b0;
      @(negedge clk);
      chk("lit6_ovf_set", err_ovf, 1);
      chk("lit6_tready_low", s_axis_tready, 0);
      step();
      drain();

      for (int c = 0; c < 4000; c++) begin
         if (c == 2000) rst_n = 1'b0;
         if (c == 2004) rst_n = 1'b1;
         s_axis_tvalid = ($urandom % 4) != 0;
         s_axis_tdata  = (($urandom % 4) == 0) ? 32'h0 :
                         (($urandom % 8) == 0) ? 32'hFFFF_FFFF : $urandom;
         s_axis_tlast  = ($urandom % 6) == 0;
         res_valid     = ($urandom % 3) == 0;
         res_data      = RES_W'({$urandom, $urandom, $urandom});
         res_eop       = $urandom % 2;
         m_axis_tready = ($urandom % 4) < ((c < 2000) ? 3 : 2);
         step();
      end
      s_axis_tvalid = 1'b0; res_valid = 1'b0;
      drain();
      repeat (3) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
